// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline hold/flush scheduler: FSM states, stall causes
// and the packed per-stage enable/flush bundle.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN,
        ST_IM_WAIT_REDIR
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_DM,
        CAUSE_MDU,
        CAUSE_HAZ,
        CAUSE_REDIR,
        CAUSE_IM
    } cause_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic pc_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_FREE  = ctrl_t'(10'b11111_0000_0);
    localparam ctrl_t CTRL_RESET = ctrl_t'(10'b00000_1111_0);

endpackage

// File: rtl/pipeline_stall_ctrl_mdu.sv
// Counts the cycles a multi-cycle MDU op has spent in EX; done on the last one.
// The counter only clears at done once EX/MEM really loads, so dm_wait holds done.
module mdu_occupancy_counter #(
    parameter int MDU_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic op,
    input  logic advance,
    output logic busy,
    output logic done
);

    localparam int CW = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(MDU_LATENCY - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!op) begin
            cnt_d = '0;
        end else if (cnt_q < LAST) begin
            cnt_d = cnt_q + CW'(1);
        end else if (advance) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = op && (cnt_q != LAST);
    assign done = op && (cnt_q == LAST);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline hold/flush scheduler: merges hazard, memory-wait and MDU
// occupancy into per-stage enables, bubbles and PC redirect select.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_use_hazard,
    input  logic            branch_stall,
    input  logic            redirect,
    input  logic            redirect_is_branch,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            im_wait,
    input  logic            dm_wait,
    input  logic            ex_mdu_op,
    output logic            pc_en,
    output logic            if_id_en,
    output logic            id_ex_en,
    output logic            ex_mem_en,
    output logic            mem_wb_en,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            ex_mem_flush,
    output logic            mem_wb_flush,
    output logic            pc_sel,
    output logic [XLEN-1:0] next_pc_redirect,
    output logic            mdu_done,
    output logic            redirect_pending
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    cause_e          cause;
    ctrl_t           ctrl;
    logic            mdu_busy;
    logic            mdu_last;

    mdu_occupancy_counter #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_cnt (
        .clk     (clk),
        .rst     (rst),
        .op      (ex_mdu_op),
        .advance (ctrl.ex_mem_en),
        .busy    (mdu_busy),
        .done    (mdu_last)
    );

    always_comb begin
        cause = CAUSE_NONE;
        if (dm_wait) begin
            cause = CAUSE_DM;
        end else if (mdu_busy) begin
            cause = CAUSE_MDU;
        end else if (ld_use_hazard || branch_stall) begin
            cause = CAUSE_HAZ;
        end else if (redirect) begin
            cause = CAUSE_REDIR;
        end else if (im_wait || state_q == ST_IM_WAIT_REDIR) begin
            cause = CAUSE_IM;
        end
    end

    always_comb begin
        ctrl             = CTRL_FREE;
        state_d          = state_q;
        tgt_d            = tgt_q;
        next_pc_redirect = (state_q == ST_IM_WAIT_REDIR) ? tgt_q : redirect_pc;

        case (cause)
            CAUSE_DM: begin
                ctrl.pc_en        = 1'b0;
                ctrl.if_id_en     = 1'b0;
                ctrl.id_ex_en     = 1'b0;
                ctrl.ex_mem_en    = 1'b0;
                ctrl.mem_wb_flush = 1'b1;
            end
            CAUSE_MDU: begin
                ctrl.pc_en        = 1'b0;
                ctrl.if_id_en     = 1'b0;
                ctrl.id_ex_en     = 1'b0;
                ctrl.ex_mem_flush = 1'b1;
            end
            CAUSE_HAZ: begin
                ctrl.pc_en       = 1'b0;
                ctrl.if_id_en    = 1'b0;
                ctrl.id_ex_flush = 1'b1;
            end
            CAUSE_REDIR: begin
                // JAL/JALR keep their ID/EX slot so the link register is written
                ctrl.pc_sel      = 1'b1;
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = redirect_is_branch;
                next_pc_redirect = redirect_pc;
                tgt_d            = redirect_pc;
                if (im_wait) begin
                    ctrl.pc_en = 1'b0;
                    state_d    = ST_IM_WAIT_REDIR;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            CAUSE_IM: begin
                ctrl.if_id_flush = 1'b1;
                if (state_q == ST_IM_WAIT_REDIR && !im_wait) begin
                    ctrl.pc_sel = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    ctrl.pc_en  = 1'b0;
                end
            end
            default: ;
        endcase

        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    assign pc_en            = ctrl.pc_en;
    assign if_id_en         = ctrl.if_id_en;
    assign id_ex_en         = ctrl.id_ex_en;
    assign ex_mem_en        = ctrl.ex_mem_en;
    assign mem_wb_en        = ctrl.mem_wb_en;
    assign if_id_flush      = ctrl.if_id_flush;
    assign id_ex_flush      = ctrl.id_ex_flush;
    assign ex_mem_flush     = ctrl.ex_mem_flush;
    assign mem_wb_flush     = ctrl.mem_wb_flush;
    assign pc_sel           = ctrl.pc_sel;
    assign mdu_done         = mdu_last && !rst;
    assign redirect_pending = (state_q == ST_IM_WAIT_REDIR) && !rst;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: each driven cycle queues its expected
// outputs; a monitor pops and compares on the falling edge.
module tb_pipeline_stall_ctrl;

    localparam int XLEN = 32;

    // {pc,if_id,id_ex,ex_mem,mem_wb en}_{if_id,id_ex,ex_mem,mem_wb flush}_pc_sel_mdu_done_pending
    localparam logic [11:0] RST   = 12'b00000_1111_0_0_0;
    localparam logic [11:0] DEF   = 12'b11111_0000_0_0_0;
    localparam logic [11:0] HAZ   = 12'b00111_0100_0_0_0;
    localparam logic [11:0] MBUSY = 12'b00011_0010_0_0_0;
    localparam logic [11:0] MDONE = 12'b11111_0000_0_1_0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ld_use_hazard = 1'b0;
    logic            branch_stall = 1'b0;
    logic            redirect = 1'b0;
    logic            redirect_is_branch = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            im_wait = 1'b0;
    logic            dm_wait = 1'b0;
    logic            ex_mdu_op = 1'b0;
    logic            pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic            pc_sel, mdu_done, redirect_pending;
    logic [XLEN-1:0] next_pc_redirect;

    typedef struct {
        string           nm;
        logic [11:0]     v;
        logic            chk_pc;
        logic [XLEN-1:0] pc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .MDU_LATENCY (4),
        .XLEN        (XLEN)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ld_use_hazard      (ld_use_hazard),
        .branch_stall       (branch_stall),
        .redirect           (redirect),
        .redirect_is_branch (redirect_is_branch),
        .redirect_pc        (redirect_pc),
        .im_wait            (im_wait),
        .dm_wait            (dm_wait),
        .ex_mdu_op          (ex_mdu_op),
        .pc_en              (pc_en),
        .if_id_en           (if_id_en),
        .id_ex_en           (id_ex_en),
        .ex_mem_en          (ex_mem_en),
        .mem_wb_en          (mem_wb_en),
        .if_id_flush        (if_id_flush),
        .id_ex_flush        (id_ex_flush),
        .ex_mem_flush       (ex_mem_flush),
        .mem_wb_flush       (mem_wb_flush),
        .pc_sel             (pc_sel),
        .next_pc_redirect   (next_pc_redirect),
        .mdu_done           (mdu_done),
        .redirect_pending   (redirect_pending)
    );

    task automatic vec(input string nm, input logic r, input logic ld, input logic bs,
                       input logic rd, input logic rib, input logic [XLEN-1:0] rpc,
                       input logic imw, input logic dmw, input logic mdu,
                       input logic [11:0] ev, input logic cp, input logic [XLEN-1:0] pc);
        exp_t e;
        @(posedge clk);
        #1;
        rst                = r;
        ld_use_hazard      = ld;
        branch_stall       = bs;
        redirect           = rd;
        redirect_is_branch = rib;
        redirect_pc        = rpc;
        im_wait            = imw;
        dm_wait            = dmw;
        ex_mdu_op          = mdu;
        e.nm     = nm;
        e.v      = ev;
        e.chk_pc = cp;
        e.pc     = pc;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                       pc_sel, mdu_done, redirect_pending};
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL %s: ctrl got %b want %b", e.nm, act, e.v);
                end
                if (e.chk_pc) begin
                    total++;
                    if (next_pc_redirect !== e.pc) begin
                        bad++;
                        $display("FAIL %s_pc: got %h want %h", e.nm, next_pc_redirect, e.pc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin : stim
        //   name        rst ld bs rd rib pc            imw dmw mdu expected                 cp pc
        vec("rst0",      1, 0, 0, 0, 0, 32'h0,        0, 0, 0, RST,                     0, 32'h0);
        vec("rst1",      1, 0, 0, 0, 0, 32'h0,        0, 0, 0, RST,                     0, 32'h0);
        vec("idle",      0, 0, 0, 0, 0, 32'h0,        0, 0, 0, DEF,                     0, 32'h0);
        vec("ld_use",    0, 1, 0, 0, 0, 32'h0,        0, 0, 0, HAZ,                     0, 32'h0);
        vec("ld_rel",    0, 0, 0, 0, 0, 32'h0,        0, 0, 0, DEF,                     0, 32'h0);
        for (int op = 0; op < 2; op++) begin
            vec("mdu_c0", 0, 0, 0, 0, 0, 32'h0,       0, 0, 1, MBUSY,                   0, 32'h0);
            vec("mdu_c1", 0, 0, 0, 0, 0, 32'h0,       0, 0, 1, MBUSY,                   0, 32'h0);
            vec("mdu_c2", 0, 0, 0, 0, 0, 32'h0,       0, 0, 1, MBUSY,                   0, 32'h0);
            vec("mdu_c3", 0, 0, 0, 0, 0, 32'h0,       0, 0, 1, MDONE,                   0, 32'h0);
        end
        vec("mdu_off",   0, 0, 0, 0, 0, 32'h0,        0, 0, 0, DEF,                     0, 32'h0);
        vec("bstall",    0, 0, 1, 0, 0, 32'h0,        0, 0, 0, HAZ,                     0, 32'h0);
        vec("im_only",   0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 12'b01111_1000_0_0_0,    0, 32'h0);
        vec("redir_imw", 0, 0, 0, 1, 1, 32'h100,      1, 0, 0, 12'b01111_1100_1_0_0,    1, 32'h100);
        vec("wait1",     0, 0, 0, 0, 0, 32'hdead,     1, 0, 0, 12'b01111_1000_0_0_1,    1, 32'h100);
        vec("wait2",     0, 0, 0, 0, 0, 32'hdead,     1, 0, 0, 12'b01111_1000_0_0_1,    1, 32'h100);
        vec("release",   0, 0, 0, 0, 0, 32'hdead,     0, 0, 0, 12'b11111_1000_1_0_1,    1, 32'h100);
        vec("after_rel", 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, DEF,                     0, 32'h0);
        vec("dm_all",    0, 1, 0, 1, 1, 32'h200,      0, 1, 0, 12'b00001_0001_0_0_0,    0, 32'h0);
        vec("dm_drop",   0, 1, 0, 1, 1, 32'h200,      0, 0, 0, HAZ,                     0, 32'h0);
        vec("jal",       0, 0, 0, 1, 0, 32'h200,      0, 0, 0, 12'b11111_1000_1_0_0,    1, 32'h200);
        vec("branch",    0, 0, 0, 1, 1, 32'h204,      0, 0, 0, 12'b11111_1100_1_0_0,    1, 32'h204);
        vec("ow_enter",  0, 0, 0, 1, 1, 32'h300,      1, 0, 0, 12'b01111_1100_1_0_0,    1, 32'h300);
        vec("ow_new",    0, 0, 0, 1, 0, 32'h400,      1, 0, 0, 12'b01111_1000_1_0_1,    1, 32'h400);
        vec("ow_rel",    0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 12'b11111_1000_1_0_1,    1, 32'h400);
        vec("ov_enter",  0, 0, 0, 1, 1, 32'h500,      1, 0, 0, 12'b01111_1100_1_0_0,    1, 32'h500);
        vec("ov_dm",     0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 12'b00001_0001_0_0_1,    0, 32'h0);
        vec("ov_haz",    0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 12'b00111_0100_0_0_1,    0, 32'h0);
        vec("ov_rel",    0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 12'b11111_1000_1_0_1,    1, 32'h500);
        vec("ov_done",   0, 0, 0, 0, 0, 32'h0,        0, 0, 0, DEF,                     0, 32'h0);
        vec("rw_enter",  0, 0, 0, 1, 1, 32'h600,      1, 0, 0, 12'b01111_1100_1_0_0,    1, 32'h600);
        vec("rw_wait",   0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 12'b01111_1000_0_0_1,    1, 32'h600);
        vec("rw_rst",    1, 0, 0, 0, 0, 32'h0,        1, 0, 0, RST,                     0, 32'h0);
        vec("rw_post",   0, 0, 0, 0, 0, 32'h0,        0, 0, 0, DEF,                     0, 32'h0);
        vec("rm_c0",     0, 0, 0, 0, 0, 32'h0,        0, 0, 1, MBUSY,                   0, 32'h0);
        vec("rm_c1",     0, 0, 0, 0, 0, 32'h0,        0, 0, 1, MBUSY,                   0, 32'h0);
        vec("rm_rst",    1, 0, 0, 0, 0, 32'h0,        0, 0, 1, RST,                     0, 32'h0);
        vec("rm_p0",     0, 0, 0, 0, 0, 32'h0,        0, 0, 1, MBUSY,                   0, 32'h0);
        vec("rm_p1",     0, 0, 0, 0, 0, 32'h0,        0, 0, 1, MBUSY,                   0, 32'h0);
        vec("rm_p2",     0, 0, 0, 0, 0, 32'h0,        0, 0, 1, MBUSY,                   0, 32'h0);
        vec("rm_p3",     0, 0, 0, 0, 0, 32'h0,        0, 0, 1, MDONE,                   0, 32'h0);
        vec("rm_off",    0, 0, 0, 0, 0, 32'h0,        0, 0, 0, DEF,                     0, 32'h0);
        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
